// File: rtl/ui_mmio_controller_if.sv
// ----------------------------------------------------------------------------
// ui_mmio_controller_if
// Processor-side IO bus between the address-decode path and the UI peripheral.
//   addr     byte address of the current access
//   wrtData  store data
//   wrtEn    store strobe, sampled at posedge clk
//   rdData   combinational read data for addr
//   hit      combinational address-match flag
// master: processor/IO path side; slave: peripheral side.
// ----------------------------------------------------------------------------
interface ui_mmio_controller_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wrtData;
    logic             wrtEn;
    logic [DBITS-1:0] rdData;
    logic             hit;

    modport master (
        output addr,
        output wrtData,
        output wrtEn,
        input  rdData,
        input  hit
    );

    modport slave (
        input  addr,
        input  wrtData,
        input  wrtEn,
        output rdData,
        output hit
    );
endinterface

// File: rtl/ui_mmio_controller.sv
// ----------------------------------------------------------------------------
// ui_mmio_controller
// Memory-mapped user-interface peripheral: debounced keys and switches, sticky
// key-press flags (write-1-to-clear), LED register and seven-segment decode.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    IO bus (addr, wrtData, wrtEn in; rdData, hit out, combinational)
//   KEY    raw push buttons, active-low
//   SW     raw switches, active-high
//   LEDR   LED drive, active-high, registered
//   HEX    segment drive, active-low, digit i at [7*i+6:7*i], segment g is MSB
// ----------------------------------------------------------------------------
module ui_mmio_controller #(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_SW          = 10,
    parameter int unsigned NUM_LEDR        = 10,
    parameter int unsigned NUM_HEX         = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] ADDR_HEX        = 32'hF000_0000,
    parameter logic [31:0] ADDR_LEDR       = 32'hF000_0004,
    parameter logic [31:0] ADDR_KEY        = 32'hF000_0010,
    parameter logic [31:0] ADDR_SW         = 32'hF000_0014,
    parameter logic [31:0] ADDR_KEYEDGE    = 32'hF000_0018
) (
    input  logic                   clk,
    input  logic                   reset,
    ui_mmio_controller_if.slave    bus,
    input  logic [NUM_KEYS-1:0]    KEY,
    input  logic [NUM_SW-1:0]      SW,
    output logic [NUM_LEDR-1:0]    LEDR,
    output logic [7*NUM_HEX-1:0]   HEX
);

    localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned HexW   = 4 * NUM_HEX;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_hex, sel_ledr, sel_key, sel_sw, sel_keyedge;

    assign sel_hex     = (bus.addr == DBITS'(ADDR_HEX));
    assign sel_ledr    = (bus.addr == DBITS'(ADDR_LEDR));
    assign sel_key     = (bus.addr == DBITS'(ADDR_KEY));
    assign sel_sw      = (bus.addr == DBITS'(ADDR_SW));
    assign sel_keyedge = (bus.addr == DBITS'(ADDR_KEYEDGE));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HexW-1:0]                    hex_q, hex_d;
    logic [NUM_LEDR-1:0]                led_q, led_d;

    logic [NUM_KEYS-1:0]                key_meta_q, key_sync_q;
    logic [NUM_KEYS-1:0]                key_stable_q, key_stable_d;
    logic [NUM_KEYS-1:0]                key_prev_q;
    logic [NUM_KEYS-1:0][CntW-1:0]      key_cnt_q, key_cnt_d;
    logic [NUM_KEYS-1:0]                key_edge_q, key_edge_d;

    logic [NUM_SW-1:0]                  sw_meta_q, sw_sync_q;
    logic [NUM_SW-1:0]                  sw_stable_q, sw_stable_d;
    logic [NUM_SW-1:0][CntW-1:0]        sw_cnt_q, sw_cnt_d;

    logic [NUM_KEYS-1:0]                key_pressed;
    logic [NUM_KEYS-1:0]                key_rise;
    logic [NUM_KEYS-1:0]                key_clr;

    // Keys are active-low on the pins; everything after the synchroniser
    // works in "pressed = 1" terms.
    assign key_pressed = ~key_sync_q;

    // ------------------------------------------------------------------
    // Debounce: a channel accepts a new level only after the synced value
    // has differed from the stable value for DEBOUNCE_CYCLES consecutive
    // cycles; any return to the stable value restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        key_stable_d = key_stable_q;
        key_cnt_d    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_pressed[i] != key_stable_q[i]) begin
                if (key_cnt_q[i] == CntMax) begin
                    key_stable_d[i] = key_pressed[i];
                end else begin
                    key_cnt_d[i] = key_cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw_sync_q[i] != sw_stable_q[i]) begin
                if (sw_cnt_q[i] == CntMax) begin
                    sw_stable_d[i] = sw_sync_q[i];
                end else begin
                    sw_cnt_d[i] = sw_cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge capture and register writes
    // ------------------------------------------------------------------
    // Press is detected one cycle after the stable level rises; a clear
    // landing on that same cycle loses to the set.
    assign key_rise = key_stable_q & ~key_prev_q;
    assign key_clr  = (bus.wrtEn && sel_keyedge) ? bus.wrtData[NUM_KEYS-1:0] : '0;

    always_comb begin
        key_edge_d = (key_edge_q & ~key_clr) | key_rise;
        hex_d      = hex_q;
        led_d      = led_q;
        if (bus.wrtEn && sel_hex) begin
            hex_d = bus.wrtData[HexW-1:0];
        end
        if (bus.wrtEn && sel_ledr) begin
            led_d = bus.wrtData[NUM_LEDR-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_q        <= '0;
            led_q        <= '0;
            key_meta_q   <= '1;
            key_sync_q   <= '1;
            key_stable_q <= '0;
            key_prev_q   <= '0;
            key_cnt_q    <= '0;
            key_edge_q   <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            sw_stable_q  <= '0;
            sw_cnt_q     <= '0;
        end else begin
            hex_q        <= hex_d;
            led_q        <= led_d;
            key_meta_q   <= KEY;
            key_sync_q   <= key_meta_q;
            key_stable_q <= key_stable_d;
            key_prev_q   <= key_stable_q;
            key_cnt_q    <= key_cnt_d;
            key_edge_q   <= key_edge_d;
            sw_meta_q    <= SW;
            sw_sync_q    <= sw_meta_q;
            sw_stable_q  <= sw_stable_d;
            sw_cnt_q     <= sw_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, zero-extended)
    // ------------------------------------------------------------------
    always_comb begin
        bus.rdData = '0;
        if (sel_hex)     bus.rdData = DBITS'(hex_q);
        if (sel_ledr)    bus.rdData = DBITS'(led_q);
        if (sel_key)     bus.rdData = DBITS'(key_stable_q);
        if (sel_sw)      bus.rdData = DBITS'(sw_stable_q);
        if (sel_keyedge) bus.rdData = DBITS'(key_edge_q);
    end

    assign bus.hit = sel_hex | sel_ledr | sel_key | sel_sw | sel_keyedge;

    // Only the low data bits are stored; the rest of the bus is don't-care.
    logic unused_wdata;
    assign unused_wdata = ^bus.wrtData;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign LEDR = led_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        HEX = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            HEX[7*i +: 7] = seg_decode(hex_q[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_ui_mmio_controller.sv
// Self-checking bench for ui_mmio_controller: behavioural model plus directed
// literal checks, then randomized traffic on bus, keys and switches.
module tb_ui_mmio_controller;

    localparam int unsigned DBITS = 32;
    localparam int unsigned NK    = 4;
    localparam int unsigned NS    = 10;
    localparam int unsigned NL    = 10;
    localparam int unsigned NH    = 6;
    localparam int unsigned DB    = 16;
    localparam int unsigned HLEN  = DB + 2;

    localparam logic [31:0] A_HEX     = 32'hF000_0000;
    localparam logic [31:0] A_LEDR    = 32'hF000_0004;
    localparam logic [31:0] A_KEY     = 32'hF000_0010;
    localparam logic [31:0] A_SW      = 32'hF000_0014;
    localparam logic [31:0] A_KEYEDGE = 32'hF000_0018;
    localparam logic [31:0] A_UNMAP   = 32'hF000_0020;

    localparam logic [41:0] HEX_ZEROS = {6{7'b1000000}};
    // Digits 5..0 = A, b, C, d, E, F
    localparam logic [41:0] HEX_ABCDEF = {7'b0001000, 7'b0000011, 7'b1000110,
                                          7'b0100001, 7'b0000110, 7'b0001110};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NK-1:0]   KEY;
    logic [NS-1:0]   SW;
    logic [NL-1:0]   LEDR;
    logic [7*NH-1:0] HEX;

    ui_mmio_controller_if #(.DBITS(DBITS)) bus ();

    ui_mmio_controller #(
        .DBITS(DBITS), .NUM_KEYS(NK), .NUM_SW(NS), .NUM_LEDR(NL),
        .NUM_HEX(NH), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a level is accepted once the 16 most recent
    // synchronised samples (raw input delayed two clocks) all oppose it.
    // ------------------------------------------------------------------
    logic [NK-1:0] kh [HLEN];   // pressed history, [0] newest raw sample
    logic [NS-1:0] sh [HLEN];
    logic [23:0]   m_hex;
    logic [NL-1:0] m_led;
    logic [NK-1:0] m_kst, m_kprev, m_kedge, m_rise, m_clr;
    logic [NS-1:0] m_sst;
    bit            m_all;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hex = '0; m_led = '0; m_kst = '0; m_kprev = '0; m_kedge = '0; m_sst = '0;
            for (int j = 0; j < HLEN; j++) begin
                kh[j] = '0;
                sh[j] = '0;
            end
        end else begin
            m_rise = m_kst & ~m_kprev;
            m_clr  = (bus.wrtEn && bus.addr == A_KEYEDGE) ? bus.wrtData[NK-1:0] : '0;
            if (bus.wrtEn && bus.addr == A_HEX)  m_hex = bus.wrtData[23:0];
            if (bus.wrtEn && bus.addr == A_LEDR) m_led = bus.wrtData[NL-1:0];
            m_kedge = (m_kedge & ~m_clr) | m_rise;
            m_kprev = m_kst;
            for (int j = HLEN - 1; j > 0; j--) begin
                kh[j] = kh[j-1];
                sh[j] = sh[j-1];
            end
            kh[0] = ~KEY;
            sh[0] = SW;
            for (int i = 0; i < NK; i++) begin
                m_all = 1'b1;
                for (int j = 2; j < HLEN; j++) if (kh[j][i] == m_kst[i]) m_all = 1'b0;
                if (m_all) m_kst[i] = ~m_kst[i];
            end
            for (int i = 0; i < NS; i++) begin
                m_all = 1'b1;
                for (int j = 2; j < HLEN; j++) if (sh[j][i] == m_sst[i]) m_all = 1'b0;
                if (m_all) m_sst[i] = ~m_sst[i];
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[n];
    endfunction

    function automatic logic [41:0] exp_hex();
        logic [41:0] r;
        for (int i = 0; i < NH; i++) r[7*i +: 7] = glyph(m_hex[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        case (a)
            A_HEX:     return {8'h0, m_hex};
            A_LEDR:    return {22'h0, m_led};
            A_KEY:     return {28'h0, m_kst};
            A_SW:      return {22'h0, m_sst};
            A_KEYEDGE: return {28'h0, m_kedge};
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic exp_hit(input logic [31:0] a);
        return (a == A_HEX) || (a == A_LEDR) || (a == A_KEY) || (a == A_SW) || (a == A_KEYEDGE);
    endfunction

    // Compare process: every cycle, 2 time units after the input-driving edge.
    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            chk("model_ledr", 64'(LEDR), 64'(m_led));
            chk("model_hex", 64'(HEX), 64'(exp_hex()));
            chk("model_rd", 64'(bus.rdData), 64'(exp_rd(bus.addr)));
            chk("model_hit", 64'(bus.hit), 64'(exp_hit(bus.addr)));
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.wrtData = d; bus.wrtEn = 1'b1;
        @(negedge clk);
        bus.wrtEn = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #3;
        chk(name, 64'(bus.rdData), 64'(exp));
    endtask

    logic [31:0] addr_pool [7];

    initial begin
        addr_pool = '{A_HEX, A_LEDR, A_KEY, A_SW, A_KEYEDGE, A_UNMAP, 32'hF000_0008};
        KEY = 4'hF; SW = '0;
        bus.addr = A_KEYEDGE; bus.wrtData = '0; bus.wrtEn = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cmp_en = 1'b1;
        #3;
        chk("reset_ledr", 64'(LEDR), 64'h0);
        chk("reset_hex", 64'(HEX), 64'(HEX_ZEROS));
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rd_chk("idle_keyedge", A_KEYEDGE, 32'h0);
        end

        // Register writes and decode
        wr(A_HEX, 32'h00AB_CDEF);
        wr(A_LEDR, 32'hFFFF_FFFF);
        rd_chk("rd_hex", A_HEX, 32'h00AB_CDEF);
        chk("hex_glyphs", 64'(HEX), 64'(HEX_ABCDEF));
        chk("ledr_all", 64'(LEDR), 64'h3FF);

        // Key press latency, then release
        @(negedge clk);
        KEY[2] = 1'b0;
        bus.addr = A_KEY;
        repeat (17) @(negedge clk);
        rd_chk("key_before_accept", A_KEY, 32'h0);
        @(negedge clk);
        rd_chk("key_accept", A_KEY, 32'h4);
        @(negedge clk);
        rd_chk("keyedge_set", A_KEYEDGE, 32'h4);
        @(negedge clk);
        KEY[2] = 1'b1;
        bus.addr = A_KEY;
        repeat (17) @(negedge clk);
        rd_chk("key_release_hold", A_KEY, 32'h4);
        @(negedge clk);
        rd_chk("key_released", A_KEY, 32'h0);
        rd_chk("keyedge_sticky", A_KEYEDGE, 32'h4);

        // Switch glitch rejected, long hold accepted
        @(negedge clk);
        SW[5] = 1'b1;
        repeat (10) @(negedge clk);
        SW[5] = 1'b0;
        repeat (30) @(negedge clk);
        rd_chk("sw_glitch", A_SW, 32'h0);
        @(negedge clk);
        SW[5] = 1'b1;
        repeat (17) @(negedge clk);
        rd_chk("sw_before_accept", A_SW, 32'h0);
        @(negedge clk);
        rd_chk("sw_accept", A_SW, 32'h020);

        // Write-1-to-clear
        wr(A_KEYEDGE, 32'h1);
        rd_chk("w1c_other_bit", A_KEYEDGE, 32'h4);
        wr(A_KEYEDGE, 32'h4);
        rd_chk("w1c_clear", A_KEYEDGE, 32'h0);

        // Clear on the cycle the press is captured: set wins
        @(negedge clk);
        KEY[2] = 1'b0;
        repeat (18) @(negedge clk);
        bus.addr = A_KEYEDGE; bus.wrtData = 32'h4; bus.wrtEn = 1'b1;
        @(negedge clk);
        bus.wrtEn = 1'b0;
        rd_chk("set_wins", A_KEYEDGE, 32'h4);
        wr(A_KEYEDGE, 32'h4);
        rd_chk("w1c_after_set", A_KEYEDGE, 32'h0);

        // Asynchronous reset mid-debounce
        @(negedge clk);
        KEY[2] = 1'b1;
        repeat (20) @(negedge clk);
        wr(A_LEDR, 32'h155);
        KEY[2] = 1'b0;
        bus.addr = A_LEDR;
        repeat (12) @(negedge clk);
        #4;
        chk("pre_reset_ledr", 64'(LEDR), 64'h155);
        reset = 1'b0;
        #1;
        chk("async_ledr", 64'(LEDR), 64'h0);
        chk("async_hex", 64'(HEX), 64'(HEX_ZEROS));
        chk("async_rd_ledr", 64'(bus.rdData), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.addr = A_KEY;
        repeat (17) @(negedge clk);
        rd_chk("post_reset_key_hold", A_KEY, 32'h0);
        @(negedge clk);
        rd_chk("post_reset_key", A_KEY, 32'h4);

        // Read-only and unmapped stores
        wr(A_SW, 32'h3FF);
        wr(A_UNMAP, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", A_UNMAP, 32'h0);
        chk("unmapped_hit", 64'(bus.hit), 64'h0);
        chk("unmapped_ledr", 64'(LEDR), 64'h0);
        chk("unmapped_hex", 64'(HEX), 64'(HEX_ZEROS));
        rd_chk("ro_sw_hit", A_SW, 32'h020);
        chk("sw_hit", 64'(bus.hit), 64'h1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.addr    = addr_pool[$urandom_range(0, 6)];
            bus.wrtEn   = ($urandom_range(0, 3) == 0);
            bus.wrtData = $urandom;
            for (int i = 0; i < NK; i++) if ($urandom_range(0, 47) == 0) KEY[i] = ~KEY[i];
            for (int i = 0; i < NS; i++) if ($urandom_range(0, 47) == 0) SW[i] = ~SW[i];
        end
        @(negedge clk);
        bus.wrtEn = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
